// File: rtl/fir_stream_mac.sv
`default_nettype none
// ============================================================================
// fir_stream_mac : signed TAPS-deep FIR, one time-shared MAC, AXI-stream I/O,
//                  runtime coefficients, round-half-up scaling and saturation.
// Revision 1.0
// ============================================================================
module fir_stream_mac #(
    parameter  int DATA_W = 6,
    parameter  int COEF_W = 8,
    parameter  int TAPS   = 8,
    parameter  int OUT_W  = 8,
    parameter  int SHIFT  = 6,
    localparam int AW     = $clog2(TAPS),
    localparam int ACC_W  = DATA_W + COEF_W + AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_fir_tdata,
    input  logic              s_axis_fir_tvalid,
    output logic              s_axis_fir_tready,
    output logic [OUT_W-1:0]  m_axis_fir_tdata,
    output logic              m_axis_fir_tvalid,
    input  logic              m_axis_fir_tready,
    input  logic              coef_wr_en,
    input  logic [AW-1:0]     coef_wr_addr,
    input  logic [COEF_W-1:0] coef_wr_data,
    output logic              sat_flag,
    output logic              busy
);
    localparam int PW = DATA_W + COEF_W;
    localparam logic [COEF_W-1:0] UNITY   = COEF_W'(2 ** SHIFT);
    localparam logic [OUT_W-1:0]  OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [COEF_W-1:0] c [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic        [AW-1:0]     idx;

    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [ACC_W-1:0]  shifted;
    logic [ACC_W-OUT_W:0]     top_bits;
    logic                     fits;
    logic [OUT_W-1:0]         scaled;
    logic                     last_tap;
    logic                     addr_ok;

    assign s_axis_fir_tready = (state == IDLE);
    assign m_axis_fir_tvalid = (state == OUT);
    assign busy              = (state != IDLE);
    assign last_tap          = (idx == AW'(TAPS - 1));
    assign addr_ok           = ({1'b0, coef_wr_addr} < (AW+1)'(TAPS));

    assign prod = PW'(x[idx]) * PW'(c[idx]);

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (SHIFT - 1);
            assign rounded = acc + HALF;
        end else begin : g_no_round
            assign rounded = acc;
        end
    endgenerate

    // The result fits OUT_W exactly when every bit from the OUT_W sign bit up is a sign copy.
    assign shifted  = rounded >>> SHIFT;
    assign top_bits = shifted[ACC_W-1:OUT_W-1];
    assign fits     = (&top_bits) | ~(|top_bits);
    assign scaled   = fits ? shifted[OUT_W-1:0] : (shifted[ACC_W-1] ? OUT_MIN : OUT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_axis_fir_tvalid) state_nxt = MAC;
            MAC:     if (last_tap) state_nxt = SCALE;
            SCALE:   state_nxt = OUT;
            OUT:     if (m_axis_fir_tready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x[k] <= '0;
            end
            for (int k = 1; k < TAPS; k++) begin
                c[k] <= '0;
            end
            c[0]             <= UNITY;
            acc              <= '0;
            idx              <= '0;
            m_axis_fir_tdata <= '0;
            sat_flag         <= 1'b0;
        end else begin
            // Write lands before the first MAC cycle, so a same-cycle accept sees it.
            if (state == IDLE && coef_wr_en && addr_ok) begin
                c[coef_wr_addr] <= coef_wr_data;
            end
            case (state)
                IDLE: begin
                    if (s_axis_fir_tvalid) begin
                        x[0] <= s_axis_fir_tdata;
                        for (int k = 1; k < TAPS; k++) begin
                            x[k] <= x[k-1];
                        end
                        acc <= '0;
                        idx <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
                    idx <= idx + AW'(1);
                end
                SCALE: begin
                    m_axis_fir_tdata <= scaled;
                    sat_flag         <= ~fits;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fir_stream_mac.sv
`default_nettype none
// Self-checking bench for fir_stream_mac: randomized and directed stimulus
// compared with a sum-of-products reference model.
module tb_fir_stream_mac;
    localparam int DATA_W = 6;
    localparam int COEF_W = 8;
    localparam int TAPS   = 8;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 6;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] s_tdata = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [OUT_W-1:0]  m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic              coef_wr_en = 1'b0;
    logic [AW-1:0]     coef_wr_addr = '0;
    logic [COEF_W-1:0] coef_wr_data = '0;
    logic              sat_flag;
    logic              busy;

    int checks = 0;
    int failures = 0;

    int m_x [TAPS];
    int m_c [TAPS];

    fir_stream_mac #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .s_axis_fir_tdata  (s_tdata),
        .s_axis_fir_tvalid (s_tvalid),
        .s_axis_fir_tready (s_tready),
        .m_axis_fir_tdata  (m_tdata),
        .m_axis_fir_tvalid (m_tvalid),
        .m_axis_fir_tready (m_tready),
        .coef_wr_en        (coef_wr_en),
        .coef_wr_addr      (coef_wr_addr),
        .coef_wr_data      (coef_wr_data),
        .sat_flag          (sat_flag),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Reference model: y = clamp(floor((sum x[k]*c[k] + 2^(SHIFT-1)) / 2^SHIFT)).
    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_x[k] = 0;
            m_c[k] = 0;
        end
        m_c[0] = 1 << SHIFT;
    endtask

    task automatic model_push(input int v);
        for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = v;
    endtask

    task automatic model_eval(output int y, output bit s);
        longint sum, num, den, q;
        sum = 0;
        for (int k = 0; k < TAPS; k++) sum += longint'(m_x[k]) * longint'(m_c[k]);
        den = longint'(1) << SHIFT;
        num = sum + den / 2;
        q = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        if (q > (2 ** (OUT_W - 1)) - 1) begin
            y = (2 ** (OUT_W - 1)) - 1; s = 1'b1;
        end else if (q < -(2 ** (OUT_W - 1))) begin
            y = -(2 ** (OUT_W - 1)); s = 1'b1;
        end else begin
            y = int'(q); s = 1'b0;
        end
    endtask

    task automatic apply_reset();
        s_tvalid = 1'b0;
        coef_wr_en = 1'b0;
        m_tready = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic write_coef(input int a, input int d);
        coef_wr_en = 1'b1;
        coef_wr_addr = AW'(a);
        coef_wr_data = COEF_W'(d);
        @(posedge clk); #1;
        coef_wr_en = 1'b0;
    endtask

    // Drives one sample (optionally with a coefficient write in the accept cycle) and returns the output.
    task automatic run_sample(input int v, input bit wr, input int wa, input int wd,
                              output int lat, output int d, output bit s, output bit to);
        lat = 0;
        while (!s_tready && lat < 50) begin @(posedge clk); #1; lat++; end
        s_tdata = DATA_W'(v);
        s_tvalid = 1'b1;
        if (wr) begin
            coef_wr_en = 1'b1;
            coef_wr_addr = AW'(wa);
            coef_wr_data = COEF_W'(wd);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        coef_wr_en = 1'b0;
        lat = 0;
        while (!m_tvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        to = !m_tvalid;
        d = int'($signed(m_tdata));
        s = sat_flag;
        if (m_tready) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (m_tdata !== '0 || m_tvalid !== 1'b0 || sat_flag !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b1)
            begin failures++; $display("FAIL reset_state: tdata=%0d tvalid=%b sat=%b busy=%b tready=%b, want 0 0 0 0 1",
                                      m_tdata, m_tvalid, sat_flag, busy, s_tready); end
        apply_reset();
        checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b1)
            begin failures++; $display("FAIL post_reset_idle: tvalid=%b busy=%b tready=%b", m_tvalid, busy, s_tready); end
    endtask

    task automatic test_passthrough();
        int vals [4];
        int lat, d, y; bit s, ys, to;
        vals[0] = 5; vals[1] = -3; vals[2] = 31; vals[3] = -32;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run_sample(vals[i], 1'b0, 0, 0, lat, d, s, to);
            model_push(vals[i]); model_eval(y, ys);
            checks++;
            if (to) begin failures++; $display("FAIL passthrough_timeout: no output for %0d", vals[i]); end
            else if (d !== vals[i] || s !== 1'b0 || d !== y || s !== ys)
                begin failures++; $display("FAIL passthrough: got %0d sat=%b, want %0d sat=0", d, s, vals[i]); end
            checks++;
            if (lat != TAPS + 1) begin failures++; $display("FAIL latency: got %0d cycles, want %0d", lat, TAPS + 1); end
        end
    endtask

    task automatic test_moving_sum();
        int pos_d [6], pos_s [6], neg_d [5], neg_s [5];
        int lat, d, y; bit s, ys, to;
        pos_d = '{31, 62, 93, 124, 127, 127}; pos_s = '{0, 0, 0, 0, 1, 1};
        neg_d = '{-32, -64, -96, -128, -128}; neg_s = '{0, 0, 0, 0, 1};
        apply_reset();
        for (int k = 0; k < TAPS; k++) begin write_coef(k, 64); m_c[k] = 64; end
        for (int i = 0; i < 6; i++) begin
            run_sample(31, 1'b0, 0, 0, lat, d, s, to);
            model_push(31); model_eval(y, ys);
            checks++;
            if (to || d !== pos_d[i] || s !== pos_s[i][0] || d !== y || s !== ys)
                begin failures++; $display("FAIL moving_sum_pos[%0d]: got %0d sat=%b, want %0d sat=%0d", i, d, s, pos_d[i], pos_s[i]); end
        end
        apply_reset();
        for (int k = 0; k < TAPS; k++) begin write_coef(k, 64); m_c[k] = 64; end
        for (int i = 0; i < 5; i++) begin
            run_sample(-32, 1'b0, 0, 0, lat, d, s, to);
            model_push(-32); model_eval(y, ys);
            checks++;
            if (to || d !== neg_d[i] || s !== neg_s[i][0] || d !== y || s !== ys)
                begin failures++; $display("FAIL moving_sum_neg[%0d]: got %0d sat=%b, want %0d sat=%0d", i, d, s, neg_d[i], neg_s[i]); end
        end
    endtask

    task automatic test_rounding();
        int ins [4], outs [4];
        int lat, d, y; bit s, ys, to;
        ins = '{3, -3, 1, -1}; outs = '{2, -1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            apply_reset();
            write_coef(0, 32); m_c[0] = 32;
            run_sample(ins[i], 1'b0, 0, 0, lat, d, s, to);
            model_push(ins[i]); model_eval(y, ys);
            checks++;
            if (to || d !== outs[i] || d !== y || s !== ys)
                begin failures++; $display("FAIL rounding(%0d): got %0d, want %0d", ins[i], d, outs[i]); end
        end
    endtask

    task automatic test_random();
        int lat, d, y, v, wa, wd; bit s, ys, to, wr;
        apply_reset();
        for (int k = 0; k < TAPS; k++) begin
            wd = $urandom_range(255) - 128;
            write_coef(k, wd); m_c[k] = wd;
        end
        for (int i = 0; i < 25; i++) begin
            v = $urandom_range(63) - 32;
            wr = (i % 5 == 4);
            wa = $urandom_range(TAPS - 1);
            wd = $urandom_range(255) - 128;
            run_sample(v, wr, wa, wd, lat, d, s, to);
            if (wr) m_c[wa] = wd;
            model_push(v); model_eval(y, ys);
            checks++;
            if (to || d !== y || s !== ys)
                begin failures++; $display("FAIL random[%0d]: got %0d sat=%b, want %0d sat=%b", i, d, s, y, ys); end
        end
    endtask

    task automatic test_backpressure();
        int lat, d, y; bit s, ys, to;
        logic [OUT_W-1:0] held_d; logic held_s;
        apply_reset();
        m_tready = 1'b0;
        s_tdata = DATA_W'(-9); s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        lat = 0;
        while (!m_tvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        model_push(-9); model_eval(y, ys);
        checks++;
        if (!m_tvalid || int'($signed(m_tdata)) !== y)
            begin failures++; $display("FAIL bp_first: tvalid=%b got %0d, want %0d", m_tvalid, $signed(m_tdata), y); end
        held_d = m_tdata; held_s = sat_flag;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== held_d || sat_flag !== held_s || s_tready !== 1'b0 || busy !== 1'b1)
                begin failures++; $display("FAIL bp_hold[%0d]: tvalid=%b tdata=%0d tready=%b busy=%b", i, m_tvalid, m_tdata, s_tready, busy); end
            if (i == 5) begin coef_wr_en = 1'b1; coef_wr_addr = '0; coef_wr_data = COEF_W'(-1); end
            @(posedge clk); #1;
            coef_wr_en = 1'b0;
        end
        m_tready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || busy !== 1'b0 || m_tdata !== held_d)
            begin failures++; $display("FAIL bp_release: tvalid=%b tready=%b busy=%b tdata=%0d", m_tvalid, s_tready, busy, m_tdata); end
        run_sample(13, 1'b0, 0, 0, lat, d, s, to);
        model_push(13); model_eval(y, ys);
        checks++;
        if (to || d !== y || s !== ys)
            begin failures++; $display("FAIL bp_write_dropped: got %0d, want %0d", d, y); end
    endtask

    task automatic test_back_to_back();
        int exp_d [$];
        bit exp_s [$];
        int cyc, n_acc, n_out, last, y, ed; bit ys, es, hs_in, hs_out;
        m_tready = 1'b1;
        s_tdata = DATA_W'($urandom); s_tvalid = 1'b1;
        cyc = 0; n_acc = 0; n_out = 0; last = -1;
        while (n_out < 3 && cyc < 200) begin
            hs_in = s_tvalid && s_tready;
            hs_out = m_tvalid && m_tready;
            if (hs_out) begin
                ed = 0; es = 1'b0;
                if (exp_d.size() > 0) begin ed = exp_d.pop_front(); es = exp_s.pop_front(); end
                checks++;
                if (int'($signed(m_tdata)) !== ed || sat_flag !== es)
                    begin failures++; $display("FAIL b2b_data: got %0d sat=%b, want %0d sat=%b", $signed(m_tdata), sat_flag, ed, es); end
                n_out++;
            end
            if (hs_in) begin
                model_push(int'($signed(s_tdata))); model_eval(y, ys);
                exp_d.push_back(y); exp_s.push_back(ys);
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != TAPS + 3)
                        begin failures++; $display("FAIL b2b_period: got %0d cycles, want %0d", cyc - last, TAPS + 3); end
                end
                last = cyc;
                n_acc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (hs_in) begin
                if (n_acc == 3) s_tvalid = 1'b0;
                else s_tdata = DATA_W'($urandom);
            end
        end
        s_tvalid = 1'b0;
        checks++;
        if (n_out != 3) begin failures++; $display("FAIL b2b_timeout: got %0d outputs, want 3", n_out); end
    endtask

    task automatic test_reset_mid_mac();
        int lat, d, y; bit s, ys, to;
        apply_reset();
        for (int k = 0; k < TAPS; k++) begin write_coef(k, 64); m_c[k] = 64; end
        run_sample(20, 1'b0, 0, 0, lat, d, s, to);
        run_sample(20, 1'b0, 0, 0, lat, d, s, to);
        s_tdata = DATA_W'(10); s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (m_tdata !== '0 || m_tvalid !== 1'b0 || sat_flag !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b1)
            begin failures++; $display("FAIL async_reset: tdata=%0d tvalid=%b sat=%b busy=%b tready=%b, want 0 0 0 0 1",
                                      m_tdata, m_tvalid, sat_flag, busy, s_tready); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            run_sample(7, 1'b0, 0, 0, lat, d, s, to);
            model_push(7); model_eval(y, ys);
            checks++;
            if (to || d !== 7 || d !== y || s !== ys)
                begin failures++; $display("FAIL post_reset_impulse[%0d]: got %0d, want 7", i, d); end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_moving_sum();
        test_rounding();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mac();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/fir_stream_mac.md
Name: fir_stream_mac

Overview:
- Parametrised successor to the fixed FIR core: signed, TAPS-deep FIR filter with AXI-stream-style input and output.
- Uses a single time-shared multiplier-accumulator sequenced by an FSM.
- Coefficients are runtime-loadable; output supports full valid/ready backpressure, round-half-up scaling and saturation.
- Sits between the tile pin wrapper (ui_in/uo_out) and the filter datapath, replacing the fixed-width FIR instance.

Parameters:
- DATA_W, 6, input sample width, signed two's complement.
- COEF_W, 8, coefficient width, signed.
- TAPS, 8, filter length (delay line depth), >=2.
- OUT_W, 8, output width, signed.
- SHIFT, 6, output scaling right-shift. Must satisfy SHIFT <= COEF_W-2.
- Localparam ACC_W = DATA_W + COEF_W + clog2(TAPS).
- Localparam AW = clog2(TAPS).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_axis_fir_tdata  in  DATA_W  input sample.
- s_axis_fir_tvalid  in  1  input sample valid.
- s_axis_fir_tready  out  1  block can accept a sample.
- m_axis_fir_tdata  out  OUT_W  filtered output sample.
- m_axis_fir_tvalid  out  1  output sample valid.
- m_axis_fir_tready  in  1  downstream accepts output.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  AW  coefficient index, 0 applies to newest sample.
- coef_wr_data  in  COEF_W  coefficient value.
- sat_flag  out  1  current output sample was saturated; valid with m_axis_fir_tvalid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; delay line x[0..TAPS-1]=0; accumulator=0; tap index=0.
  - Coefficients: c[0]=2^SHIFT (unity passthrough), c[1..TAPS-1]=0.
  - Outputs: m_axis_fir_tdata=0, m_axis_fir_tvalid=0, sat_flag=0, busy=0, s_axis_fir_tready=1 once in IDLE.
- FSM states: IDLE, MAC, SCALE, OUT.
- IDLE:
  - s_axis_fir_tready=1.
  - On tvalid&tready (cycle T): x[k]<=x[k-1] for k>=1, x[0]<=sample; acc<=0; idx<=0; go MAC.
- MAC:
  - One tap per cycle: acc <= acc + x[idx]*c[idx] (full-precision signed product, sign-extended to ACC_W).
  - idx increments each cycle; after idx=TAPS-1 go SCALE. MAC occupies exactly TAPS cycles.
- SCALE (1 cycle):
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift; skip the add when SHIFT=0).
  - If r > 2^(OUT_W-1)-1, output max and sat_flag=1; if r < -2^(OUT_W-1), output min and sat_flag=1; else output r and sat_flag=0.
  - Register result into m_axis_fir_tdata, set m_axis_fir_tvalid=1, go OUT.
- OUT:
  - m_axis_fir_tdata and sat_flag held stable while tvalid=1 and tready=0.
  - On tvalid&tready: m_axis_fir_tvalid<=0, go IDLE. m_axis_fir_tdata keeps its last value.
- Timing:
  - Latency: sample accepted at edge T gives m_axis_fir_tvalid=1 after edge T+TAPS+1.
  - Minimum sample period with tready held high: TAPS+3 cycles.
- s_axis_fir_tready=0 in MAC, SCALE and OUT. Input is never accepted while an output is pending.
- Coefficient writes:
  - Honoured only in IDLE (busy=0) with coef_wr_addr < TAPS.
  - Writes in other states or to out-of-range addresses are silently dropped.
  - A write and an input handshake in the same IDLE cycle: the new coefficient is used for that sample.
- Reset asserted mid-MAC or in OUT: the in-flight sample is discarded, all state returns to reset values immediately, and the loaded coefficients are lost.
- Accumulator never overflows, because ACC_W provides full headroom for TAPS products.

Test Plan:
- Post-reset passthrough: feed 5, -3, 31, -32 with m_axis_fir_tready=1 -> outputs 5, -3, 31, -32, sat_flag=0 each.
- Moving sum with all c[k]=64 and input held at 31 -> outputs 31, 62, 93, 124, 127(sat_flag=1), then 127 steady. Input -32 held -> outputs -32, -64, -96, -128, -128(sat_flag=1).
- Rounding with c[0]=32, others 0: input 3 -> 2; input -3 -> -1; input 1 -> 1; input -1 -> 0.
- Latency/backpressure:
  - Valid appears exactly 9 cycles after accept.
  - Hold m_axis_fir_tready=0 for 20 cycles: tvalid and tdata stay stable, s_axis_fir_tready=0, and a coefficient write is ignored.
  - Release tready: exactly one transfer, then back to IDLE.
- Reset mid-MAC: after loading c[k]=64, accept a sample and pull reset low at MAC cycle 3 -> all outputs 0 asynchronously. After release, input 7 -> output 7 (impulse coefficients restored, delay line cleared).
